// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input word FIFO, runtime bit divisor, optional parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the breakReq input and line-break generation.
module uart_tx_fifo #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CLK_DIV_W  = 16
) (
  input  logic                        clkTx,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        dataIn,
  input  logic                        dataValid,
  output logic                        dataReady,
  input  logic [CLK_DIV_W-1:0]        clkDiv,
  input  logic [1:0]                  parityMode,
  input  logic                        twoStop,
`ifdef UART_TX_BREAK_EN
  input  logic                        breakReq,
`endif
  output logic                        serialOut,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned IdxW = $clog2(DATA_BITS);
  localparam logic [PtrW:0]        Full    = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0]        CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0]      PtrOne  = PtrW'(1);
  localparam logic [IdxW-1:0]      IdxOne  = IdxW'(1);
  localparam logic [IdxW-1:0]      LastIdx = IdxW'(DATA_BITS - 1);
  localparam logic [CLK_DIV_W-1:0] DivOne  = CLK_DIV_W'(1);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop
`ifdef UART_TX_BREAK_EN
    , StBreak, StMark
`endif
  } state_e;

  // FIFO storage is not reset; the pointers and count define its contents.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q, count_d;
  logic                 push, pop;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic [CLK_DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, div_eff;
  logic [1:0]           par_q, par_d;
  logic                 two_q, two_d, stop2_q, stop2_d, ser_q, ser_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 bit_end, decide;

  assign dataReady = (count_q != Full);
  assign push      = dataValid & dataReady;
  assign fifoCount = count_q;
  assign serialOut = ser_q;
  assign busy      = (state_q != StIdle);
  assign div_eff   = (clkDiv == '0) ? DivOne : clkDiv;
  assign bit_end   = (cnt_q == div_q - DivOne);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (pop && !push) begin
      count_d = count_q - CntOne;
    end
  end

  always_comb begin
    state_d = state_q;
    ser_d   = ser_q;
    cnt_d   = bit_end ? '0 : cnt_q + DivOne;
    idx_d   = idx_q;
    stop2_d = stop2_q;
    word_d  = word_q;
    div_d   = div_q;
    par_d   = par_q;
    two_d   = two_q;
    pop     = 1'b0;
    decide  = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d  = '0;
        decide = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          ser_d   = word_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q != LastIdx) begin
            idx_d = idx_q + IdxOne;
            ser_d = word_q[idx_q + IdxOne];
          end else if (par_q == 2'b01 || par_q == 2'b10) begin
            state_d = StParity;
            ser_d   = (par_q == 2'b01) ? ~^word_q : ^word_q;
          end else begin
            state_d = StStop;
            ser_d   = 1'b1;
            stop2_d = 1'b0;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          ser_d   = 1'b1;
          stop2_d = 1'b0;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (two_q && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            decide = 1'b1;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      StBreak: begin
        cnt_d = '0;
        if (!breakReq) begin
          state_d = StMark;
          ser_d   = 1'b1;
          div_d   = div_eff;
        end
      end
      StMark: begin
        if (bit_end) begin
          decide = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Break wins over queued data; after mark-after-break only the data decision applies.
    if (decide) begin
`ifdef UART_TX_BREAK_EN
      if (breakReq && state_q != StMark) begin
        state_d = StBreak;
        ser_d   = 1'b0;
      end else
`endif
      if (count_q != '0) begin
        pop     = 1'b1;
        state_d = StStart;
        ser_d   = 1'b0;
        cnt_d   = '0;
        stop2_d = 1'b0;
        word_d  = mem_q[rd_ptr_q];
        div_d   = div_eff;
        par_d   = parityMode;
        two_d   = twoStop;
      end else begin
        state_d = StIdle;
        ser_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clkTx) begin
    if (push) begin
      mem_q[wr_ptr_q] <= dataIn;
    end
  end

  always_ff @(posedge clkTx or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      ser_q    <= 1'b1;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop2_q  <= 1'b0;
      word_q   <= '0;
      div_q    <= DivOne;
      par_q    <= 2'b00;
      two_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      count_q <= count_d;
      state_q <= state_d;
      ser_q   <= ser_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop2_q <= stop2_d;
      word_q  <= word_d;
      div_q   <= div_d;
      par_q   <= par_d;
      two_q   <= two_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: frame shape, parity, back-to-back, reset, break.
module tb_uart_tx_fifo;

  logic        clkTx = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  dataIn = 8'h00;
  logic        dataValid = 1'b0;
  logic        dataReady;
  logic [15:0] clkDiv = 16'd4;
  logic [1:0]  parityMode = 2'b00;
  logic        twoStop = 1'b0;
  logic        breakReq = 1'b0;
  logic        serialOut;
  logic        busy;
  logic [2:0]  fifoCount;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clkTx = ~clkTx;

  uart_tx_fifo #(
    .DATA_BITS (8),
    .FIFO_DEPTH(4),
    .CLK_DIV_W (16)
  ) dut (
    .clkTx     (clkTx),
    .reset     (reset),
    .dataIn    (dataIn),
    .dataValid (dataValid),
    .dataReady (dataReady),
    .clkDiv    (clkDiv),
    .parityMode(parityMode),
    .twoStop   (twoStop),
`ifdef UART_TX_BREAK_EN
    .breakReq  (breakReq),
`endif
    .serialOut (serialOut),
    .busy      (busy),
    .fifoCount (fifoCount)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Samples every cycle of one frame on the falling edge, starting with the first start-bit cycle.
  task automatic expect_frame(input logic [7:0] w, input int div, input logic [1:0] pm,
                              input logic two, input string tag);
    logic bits [12];
    int   nb;
    nb = 0;
    bits[nb] = 1'b0; nb++;
    for (int i = 0; i < 8; i++) begin
      bits[nb] = w[i]; nb++;
    end
    if (pm == 2'b01) begin
      bits[nb] = ~^w; nb++;
    end else if (pm == 2'b10) begin
      bits[nb] = ^w; nb++;
    end
    bits[nb] = 1'b1; nb++;
    if (two) begin
      bits[nb] = 1'b1; nb++;
    end
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < div; c++) begin
        @(negedge clkTx);
        check({tag, " ser"}, serialOut, bits[k]);
        check({tag, " busy"}, busy, 1);
      end
    end
  endtask

  // Single push into an idle transmitter; returns on the falling edge before the start bit.
  task automatic push_one(input logic [7:0] w);
    @(negedge clkTx);
    dataIn    = w;
    dataValid = 1'b1;
    @(negedge clkTx);
    dataValid = 1'b0;
    check("pre_start ser", serialOut, 1);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clkTx);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle ser"}, serialOut, 1);
    check({tag, " idle cnt"}, fifoCount, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic saw_low;

    // Reset state
    #12;
    check("rst ser", serialOut, 1);
    check("rst busy", busy, 0);
    check("rst ready", dataReady, 1);
    check("rst cnt", fifoCount, 0);
    @(negedge clkTx);
    reset = 1'b1;
    repeat (2) @(negedge clkTx);

    // 0xA5, div 4, no parity, one stop: 40 busy cycles
    push_one(8'hA5);
    expect_frame(8'hA5, 4, 2'b00, 1'b0, "a5");
    idle_check("a5");

    // Parity odd / even and two stop bits on 0x07
    parityMode = 2'b01;
    push_one(8'h07);
    expect_frame(8'h07, 4, 2'b01, 1'b0, "odd");
    idle_check("odd");
    parityMode = 2'b10;
    twoStop    = 1'b1;
    push_one(8'h07);
    expect_frame(8'h07, 4, 2'b10, 1'b1, "even2");
    idle_check("even2");

    // clkDiv 0 behaves as 1; parity mode 11 means none
    clkDiv     = 16'd0;
    parityMode = 2'b11;
    twoStop    = 1'b0;
    push_one(8'h96);
    expect_frame(8'h96, 1, 2'b00, 1'b0, "div0");
    idle_check("div0");

    // Back-to-back: six words, FIFO fills, no idle gaps
    clkDiv     = 16'd16;
    parityMode = 2'b00;
    @(negedge clkTx);
    dataIn    = 8'h01;
    dataValid = 1'b1;
    fork
      begin : prod
        logic acc;
        int   guard;
        @(negedge clkTx);
        for (int w = 2; w <= 6; w++) begin
          dataIn = 8'(w);
          if (w == 3) check("pushpop cnt", fifoCount, 1);
          if (w == 6) begin
            check("full cnt", fifoCount, 4);
            check("full ready", dataReady, 0);
          end
          guard = 0;
          do begin
            acc = dataReady;
            @(negedge clkTx);
            guard++;
          end while (!acc && guard < 400);
          if (!acc) check("accept timeout", 0, 1);
        end
        dataValid = 1'b0;
      end
      begin : cons
        @(negedge clkTx);
        for (int w = 1; w <= 6; w++) expect_frame(8'(w), 16, 2'b00, 1'b0, "b2b");
      end
    join
    idle_check("b2b");

    // Divisor change mid-frame only affects the next frame
    clkDiv = 16'd4;
    @(negedge clkTx);
    dataIn    = 8'h3C;
    dataValid = 1'b1;
    fork
      begin : prod4
        @(negedge clkTx);
        dataIn = 8'hC3;
        @(negedge clkTx);
        dataValid = 1'b0;
        repeat (8) @(negedge clkTx);
        clkDiv = 16'd8;
      end
      begin : cons4
        @(negedge clkTx);
        expect_frame(8'h3C, 4, 2'b00, 1'b0, "div4");
        expect_frame(8'hC3, 8, 2'b00, 1'b0, "div8");
      end
    join
    idle_check("divchg");

    // Asynchronous reset mid-DATA with words queued
    clkDiv = 16'd4;
    @(negedge clkTx);
    dataIn    = 8'h11;
    dataValid = 1'b1;
    @(negedge clkTx);
    dataIn = 8'h22;
    @(negedge clkTx);
    dataIn = 8'h33;
    @(negedge clkTx);
    dataValid = 1'b0;
    repeat (8) @(negedge clkTx);
    check("pre_rst busy", busy, 1);
    check("pre_rst cnt", fifoCount, 2);
    #2;
    reset = 1'b0;
    #1;
    check("arst ser", serialOut, 1);
    check("arst busy", busy, 0);
    check("arst cnt", fifoCount, 0);
    check("arst ready", dataReady, 1);
    repeat (2) @(negedge clkTx);
    reset   = 1'b1;
    saw_low = 1'b0;
    repeat (100) begin
      @(negedge clkTx);
      if (serialOut !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    check("post_rst quiet", saw_low, 0);
    check("post_rst cnt", fifoCount, 0);

`ifdef UART_TX_BREAK_EN
    // Break after the current frame, mark-after-break, then the queued word
    @(negedge clkTx);
    dataIn    = 8'h5A;
    dataValid = 1'b1;
    fork
      begin : prod6
        @(negedge clkTx);
        dataIn = 8'h81;
        @(negedge clkTx);
        dataValid = 1'b0;
        repeat (4) @(negedge clkTx);
        breakReq = 1'b1;
      end
      begin : cons6
        @(negedge clkTx);
        expect_frame(8'h5A, 4, 2'b00, 1'b0, "brk_f1");
        repeat (20) begin
          @(negedge clkTx);
          check("brk ser", serialOut, 0);
          check("brk busy", busy, 1);
          check("brk cnt", fifoCount, 1);
        end
        breakReq = 1'b0;
        repeat (4) begin
          @(negedge clkTx);
          check("mab ser", serialOut, 1);
          check("mab busy", busy, 1);
        end
        expect_frame(8'h81, 4, 2'b00, 1'b0, "brk_f2");
      end
    join
    idle_check("brk");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
